// File: rtl/pe_array_param.sv
`default_nettype none
// ============================================================================
//  Module      : pe_array_param
//  Description : Parametrised output-stationary systolic MAC array computing
//                C = A x B (A is ROWS x K, B is K x COLS) over K operand
//                beats. Operands are skewed internally so the feeder presents
//                unskewed vectors. Results drain serially, row-major, through
//                a valid/ready port.
//  Ports       : clk, rst_n            clock, async active-low reset
//                start, k_len, sgn     run request, depth K, signed mode
//                busy                  high whenever not idle
//                in_valid, in_ready    operand beat handshake
//                a_data, b_data        A column k / B row k (unskewed)
//                res_valid, res_ready  result handshake
//                res_data, res_row,
//                res_col               result value and its (row, col)
//                done                  one-cycle pulse after last result
//  Revision    : 1.0  initial release
// ============================================================================
module pe_array_param #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 32,
    parameter int KW   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [KW-1:0]                           k_len,
    input  logic                                    sgn,
    output logic                                    busy,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [ROWS*DW-1:0]                      a_data,
    input  logic [COLS*DW-1:0]                      b_data,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [AW-1:0]                           res_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] res_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] res_col,
    output logic                                    done
);

    localparam int c_RIW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_CIW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_FLUSH = ROWS + COLS - 1;
    localparam int c_FW    = $clog2(c_FLUSH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    logic [KW-1:0]      r_klen;
    logic [KW-1:0]      r_kcnt;
    logic [c_FW-1:0]    r_fcnt;
    logic               r_sgn;

    // Every skew, pipe and accumulator register moves only on an advance, so
    // an in_valid gap in LOAD freezes the whole array rather than injecting
    // a bubble.
    logic w_adv;
    logic w_clr;
    logic w_inj;

    assign w_adv    = ((r_state == S_LOAD) && in_valid) || (r_state == S_FLUSH);
    assign w_clr    = (r_state == S_IDLE) && start;
    assign w_inj    = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign in_ready = (r_state == S_LOAD);

    logic [DW-1:0] w_a_in [ROWS][COLS];
    logic [DW-1:0] w_b_in [ROWS][COLS];
    logic [AW-1:0] w_acc  [ROWS][COLS];

    // ------------------------------------------------------------------
    // Input skew: row r delayed by r advances, column c by c advances.
    // Zeros are injected during FLUSH so the stages empty themselves.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic [DW-1:0] w_inj_a;
        assign w_inj_a = w_inj ? a_data[r*DW +: DW] : '0;
        if (r == 0) begin : g_direct
            assign w_a_in[r][0] = w_inj_a;
        end else begin : g_delay
            logic [DW-1:0] r_sr [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) r_sr[i] <= '0;
                end else if (w_adv) begin
                    r_sr[0] <= w_inj_a;
                    for (int i = 1; i < r; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_a_in[r][0] = r_sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        logic [DW-1:0] w_inj_b;
        assign w_inj_b = w_inj ? b_data[c*DW +: DW] : '0;
        if (c == 0) begin : g_direct
            assign w_b_in[0][c] = w_inj_b;
        end else begin : g_delay
            logic [DW-1:0] r_sr [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) r_sr[i] <= '0;
                end else if (w_adv) begin
                    r_sr[0] <= w_inj_b;
                    for (int i = 1; i < c; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_b_in[0][c] = r_sr[c-1];
        end
    end

    // ------------------------------------------------------------------
    // Processing elements. The last column has no rightward A register and
    // the last row no downward B register since nothing consumes them.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic        [2*DW-1:0] w_ax;
            logic        [2*DW-1:0] w_bx;
            logic        [2*DW-1:0] w_prod;
            logic signed [2*DW-1:0] w_ps;
            logic        [AW-1:0]   w_term;
            logic        [AW-1:0]   r_acc;

            // Sign- or zero-extending both operands to 2*DW and keeping the
            // low 2*DW product bits yields the exact full-width product.
            assign w_ax   = r_sgn ? {{DW{w_a_in[r][c][DW-1]}}, w_a_in[r][c]}
                                  : {{DW{1'b0}}, w_a_in[r][c]};
            assign w_bx   = r_sgn ? {{DW{w_b_in[r][c][DW-1]}}, w_b_in[r][c]}
                                  : {{DW{1'b0}}, w_b_in[r][c]};
            assign w_prod = w_ax * w_bx;
            assign w_ps   = w_prod;
            assign w_term = r_sgn ? AW'(w_ps) : AW'(w_prod);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     r_acc <= '0;
                else if (w_clr) r_acc <= '0;
                else if (w_adv) r_acc <= r_acc + w_term;
            end
            assign w_acc[r][c] = r_acc;

            if (c < COLS - 1) begin : g_afwd
                logic [DW-1:0] r_a;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)     r_a <= '0;
                    else if (w_adv) r_a <= w_a_in[r][c];
                end
                assign w_a_in[r][c+1] = r_a;
            end

            if (r < ROWS - 1) begin : g_bfwd
                logic [DW-1:0] r_b;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)     r_b <= '0;
                    else if (w_adv) r_b <= w_b_in[r][c];
                end
                assign w_b_in[r+1][c] = r_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next drain index (row-major walk) and its result.
    // ------------------------------------------------------------------
    logic [c_RIW-1:0] w_nrow;
    logic [c_CIW-1:0] w_ncol;
    logic             w_last;

    always_comb begin
        w_nrow = res_row;
        w_ncol = res_col + c_CIW'(1);
        if (res_col == c_CIW'(COLS - 1)) begin
            w_ncol = '0;
            w_nrow = res_row + c_RIW'(1);
        end
    end

    assign w_last = (res_row == c_RIW'(ROWS - 1)) && (res_col == c_CIW'(COLS - 1));

    // ------------------------------------------------------------------
    // Control FSM with registered result port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_klen    <= '0;
            r_kcnt    <= '0;
            r_fcnt    <= '0;
            r_sgn     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
            res_col   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_klen  <= k_len;
                        r_sgn   <= sgn;
                        r_kcnt  <= '0;
                        r_state <= (k_len == '0) ? S_DRAIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_kcnt == r_klen - KW'(1)) begin
                            r_fcnt  <= '0;
                            r_state <= S_FLUSH;
                        end else begin
                            r_kcnt <= r_kcnt + KW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == c_FW'(c_FLUSH - 1)) r_state <= S_DRAIN;
                    else                              r_fcnt  <= r_fcnt + c_FW'(1);
                end
                S_DRAIN: begin
                    if (!res_valid) begin
                        // First drain cycle: present C[0][0].
                        res_valid <= 1'b1;
                        res_row   <= '0;
                        res_col   <= '0;
                        res_data  <= w_acc[0][0];
                    end else if (res_ready) begin
                        if (w_last) begin
                            res_valid <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            res_row  <= w_nrow;
                            res_col  <= w_ncol;
                            res_data <= w_acc[w_nrow][w_ncol];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_array_param
//  Description : Self-checking bench for pe_array_param. Expected results are
//                computed as plain matrix products and queued when a run is
//                issued; a monitor pops and compares on every result
//                handshake. A second instance with AW=16 exercises wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_array_param;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int KW   = 8;
    localparam int NR   = ROWS * COLS;
    localparam int ADW  = ROWS * DW;
    localparam int BDW  = COLS * DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            sgn = 1'b0;
    logic            busy;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [ADW-1:0]  a_data = '0;
    logic [BDW-1:0]  b_data = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [AW-1:0]   res_data;
    logic [1:0]      res_row;
    logic [1:0]      res_col;
    logic            done;

    // Second instance: 16-bit accumulators
    logic            s_start = 1'b0;
    logic [KW-1:0]   s_k_len = '0;
    logic            s_busy;
    logic            s_in_valid = 1'b0;
    logic            s_in_ready;
    logic [ADW-1:0]  s_a_data = '0;
    logic [BDW-1:0]  s_b_data = '0;
    logic            s_res_valid;
    logic [15:0]     s_res_data;
    logic [1:0]      s_res_row;
    logic [1:0]      s_res_col;
    logic            s_done;

    always #5 clk = ~clk;

    pe_array_param #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .sgn(sgn),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .b_data(b_data), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
        .res_col(res_col), .done(done)
    );

    pe_array_param #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(16), .KW(KW)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_k_len), .sgn(1'b0),
        .busy(s_busy), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a_data(s_a_data), .b_data(s_b_data), .res_valid(s_res_valid),
        .res_ready(1'b1), .res_data(s_res_data), .res_row(s_res_row),
        .res_col(s_res_col), .done(s_done)
    );

    typedef struct {
        int            row;
        int            col;
        logic [AW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   pops = 0;
    int   dones = 0;
    int   irdy = 0;
    int   cyc = 0;
    bit   rdy_mode = 1'b0;

    int   am [ROWS][32];
    int   bm [32][COLS];

    bit            held = 1'b0;
    logic [AW-1:0] h_data;
    logic [3:0]    h_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: C[r][c] = sum_k A[r][k]*B[k][c], modulo 2^AW.
    function automatic logic [AW-1:0] ref_c(input int r, input int c, input int k, input bit s);
        longint sum = 0;
        longint av, bv;
        for (int kk = 0; kk < k; kk++) begin
            av = (s && am[r][kk] >= 128) ? am[r][kk] - 256 : am[r][kk];
            bv = (s && bm[kk][c] >= 128) ? bm[kk][c] - 256 : bm[kk][c];
            sum += av * bv;
        end
        return AW'(sum);
    endfunction

    // Result-ready pattern: always high, or high one cycle in four.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        res_ready = rdy_mode ? (cyc % 4 == 0) : 1'b1;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (done) dones++;
            if (in_ready) irdy++;
            if (held) begin
                chk("hold_valid", 64'(res_valid), 64'd1);
                chk("hold_data", 64'(res_data), 64'(h_data));
                chk("hold_idx", 64'({res_row, res_col}), 64'(h_idx));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none", res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("res_row", 64'(res_row), 64'(e.row));
                    chk("res_col", 64'(res_col), 64'(e.col));
                    pops++;
                end
            end
            held   = res_valid && !res_ready;
            h_data = res_data;
            h_idx  = {res_row, res_col};
        end
    end

    // amode: 0 random, 1 identity A with B[k][c]=4k+c+1, 2 A=0xFE, B=3
    task automatic run(input int k, input bit s, input int amode, input bit gaps,
                       input bit junk, input bit abort);
        int n = 0;
        int guard = 0;
        int d0, p0, i0;
        logic [ADW-1:0] av;
        logic [BDW-1:0] bv;
        for (int kk = 0; kk < k; kk++) begin
            for (int r = 0; r < ROWS; r++)
                am[r][kk] = (amode == 0) ? int'($urandom_range(0, 255)) :
                            (amode == 1) ? ((r == kk) ? 1 : 0) : 254;
            for (int c = 0; c < COLS; c++)
                bm[kk][c] = (amode == 0) ? int'($urandom_range(0, 255)) :
                            (amode == 1) ? 4 * kk + c + 1 : 3;
        end
        if (!abort)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    sb.push_back('{row: r, col: c, data: ref_c(r, c, k, s)});
        d0 = dones; p0 = pops; i0 = irdy;
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(k); sgn = s;
        @(posedge clk); #1;
        start = 1'b0;
        while (n < k && guard < 2000) begin
            in_valid = gaps ? 1'($urandom) : 1'b1;
            for (int r = 0; r < ROWS; r++) av[r*DW +: DW] = am[r][n][DW-1:0];
            for (int c = 0; c < COLS; c++) bv[c*DW +: DW] = bm[n][c][DW-1:0];
            a_data = in_valid ? av : ADW'($urandom);
            b_data = in_valid ? bv : BDW'($urandom);
            start  = junk ? 1'($urandom) : 1'b0;
            k_len  = KW'($urandom);
            sgn    = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) n++;
            guard++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (guard >= 2000) chk("beat_timeout", 64'(n), 64'(k));
        if (abort) begin
            @(posedge clk); #1;
            chk("flush_busy", 64'(busy), 64'd1);
            chk("flush_in_ready", 64'(in_ready), 64'd0);
            #2 rst_n = 1'b0;
            #1;
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_in_ready", 64'(in_ready), 64'd0);
            chk("abort_res_valid", 64'(res_valid), 64'd0);
            chk("abort_out", 64'({done, res_data, res_row, res_col}), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        guard = 0;
        while (guard < 1000) begin
            // Enough results remain that the array cannot be idle at the next edge.
            start = junk && (sb.size() >= 2);
            k_len = KW'($urandom);
            @(negedge clk);
            if (dones > d0) break;
            guard++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (guard >= 1000) chk("done_timeout", 64'(dones - d0), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_count", 64'(dones - d0), 64'd1);
        chk("handshakes", 64'(pops - p0), 64'(NR));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        if (k == 0) chk("no_in_ready", 64'(irdy - i0), 64'd0);
    endtask

    initial begin
        int cnt;
        int guard;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_out", 64'({done, res_data, res_row, res_col}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(4, 1'b0, 1, 1'b0, 1'b0, 1'b0);   // identity -> 1..16
        run(3, 1'b1, 2, 1'b0, 1'b0, 1'b0);   // -18 each
        run(3, 1'b0, 2, 1'b0, 1'b0, 1'b0);   // 2286 each
        rdy_mode = 1'b1;
        run(5, 1'b0, 0, 1'b1, 1'b1, 1'b0);   // gaps + backpressure
        run(5, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        run(0, 1'b0, 0, 1'b0, 1'b1, 1'b0);   // k_len = 0
        rdy_mode = 1'b0;
        run(3, 1'b0, 0, 1'b0, 1'b0, 1'b1);   // reset during FLUSH
        run(4, 1'b1, 0, 1'b0, 1'b0, 1'b0);   // no residue after abort
        for (int t = 0; t < 6; t++) begin
            rdy_mode = 1'($urandom);
            run(int'($urandom_range(1, 12)), 1'($urandom), 0, 1'($urandom), 1'b1, 1'b0);
        end
        rdy_mode = 1'b0;

        // Wrap test on the 16-bit instance: 2*255*255 mod 65536 = 64514.
        @(posedge clk); #1;
        s_start = 1'b1; s_k_len = KW'(2);
        @(posedge clk); #1;
        s_start = 1'b0;
        s_in_valid = 1'b1; s_a_data = '1; s_b_data = '1;
        cnt = 0; guard = 0;
        while (guard < 300) begin
            @(negedge clk);
            if (s_res_valid) begin
                chk("wrap_data", 64'(s_res_data), 64'd64514);
                chk("wrap_idx", 64'({s_res_row, s_res_col}), 64'(cnt));
                cnt++;
            end
            if (s_done) break;
            if (!s_in_ready) s_in_valid = 1'b0;
            guard++;
        end
        s_in_valid = 1'b0;
        chk("wrap_count", 64'(cnt), 64'(NR));
        @(posedge clk); #1;
        chk("wrap_busy", 64'(s_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
